// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter, branch target table, shift-carry register
// and IDLE/RUN/DONE run controller sitting just after the ALU.
//
// state | meaning
// IDLE  | after reset; prog_ctr holds, waiting for start
// RUN   | executing; prog_ctr advances or branches each edge
// DONE  | halt seen; prog_ctr holds at halt address, done = 1
module pc_branch_unit #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             branch,
  input  logic             zero,
  input  logic [LUT_W-1:0] target_sel,
  input  logic             halt,
  input  logic             sc_o,
  input  logic             sc_load,
  input  logic             sc_clr,
  input  logic             lut_we,
  input  logic [LUT_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             sc_i,
  output logic             running,
  output logic             done
);

  localparam int LUT_N = 1 << LUT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] branch_target;

  // Combinational table read; a same-cycle write is only seen next cycle.
  assign branch_target = lut[target_sel];

  // Branch target table: synchronous write in any state, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Run controller and program counter with registered state decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            prog_ctr <= '0;
            running  <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            prog_ctr <= '0;
          end else if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (branch && zero) begin
            prog_ctr <= branch_target;
          end else begin
            prog_ctr <= prog_ctr + PC_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          prog_ctr <= '0;
          running  <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Shift carry: restart or clear wins; load only while running and not halting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_i <= 1'b0;
    end else if (start || sc_clr) begin
      sc_i <= 1'b0;
    end else if (state == RUN && !halt && sc_load) begin
      sc_i <= sc_o;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed vector table, PC wrap run, async reset
// and a randomized phase against a behavioural model.
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start, branch, zero, halt, sc_o, sc_load, sc_clr, lut_we;
  logic [4:0] target_sel, lut_waddr;
  logic [9:0] lut_wdata;
  logic [9:0] prog_ctr;
  logic       sc_i, running, done;

  int total = 0;
  int bad   = 0;

  pc_branch_unit #(.PC_W(10), .LUT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .branch(branch), .zero(zero),
    .target_sel(target_sel), .halt(halt), .sc_o(sc_o), .sc_load(sc_load),
    .sc_clr(sc_clr), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .sc_i(sc_i), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, br, zr; int sel; bit hl, so, ld, cl, we; int wa, wd;
    int pc; bit sc, run, dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit st, br, zr, input int sel, input bit hl, so, ld, cl, we,
                     input int wa, wd, pc, input bit sc, run, dn);
    vec_t v;
    v.st = st; v.br = br; v.zr = zr; v.sel = sel; v.hl = hl; v.so = so; v.ld = ld;
    v.cl = cl; v.we = we; v.wa = wa; v.wd = wd; v.pc = pc; v.sc = sc; v.run = run; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int pc, input bit sc, run, dn);
    chk({nm, " prog_ctr"}, int'(prog_ctr), pc);
    chk({nm, " sc_i"}, int'(sc_i), int'(sc));
    chk({nm, " running"}, int'(running), int'(run));
    chk({nm, " done"}, int'(done), int'(dn));
  endtask

  task automatic drive(input bit st, br, zr, input int sel, input bit hl, so, ld, cl, we,
                       input int wa, wd);
    start = st; branch = br; zero = zr; target_sel = 5'(sel); halt = hl;
    sc_o = so; sc_load = ld; sc_clr = cl; lut_we = we; lut_waddr = 5'(wa); lut_wdata = 10'(wd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  int m_state;  // 0 idle, 1 run, 2 done
  int m_pc;
  bit m_sc;
  int m_lut[32];

  task automatic model_step();
    int tgt;
    tgt = m_lut[target_sel];
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    if (start) begin
      m_state = 1; m_pc = 0; m_sc = 0;
    end else begin
      if (sc_clr) m_sc = 0;
      else if (m_state == 1 && !halt && sc_load) m_sc = sc_o;
      if (m_state == 1) begin
        if (halt) m_state = 2;
        else if (branch && zero) m_pc = tgt;
        else m_pc = (m_pc + 1) % 1024;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // directed vector table (expected values are after the edge)
    //  st br zr sel hl so ld cl we wa wd     pc   sc run dn
    add(0, 1, 1, 3, 1, 1, 1, 0, 0, 0, 0,      0,   0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,   0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h155,  1,   0, 1, 0);
    for (int i = 2; i <= 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, 0, 1, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,      'h155, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,   0, 1, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, 0, 1, 0);
    add(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0,      6,   0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      7,   0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,      8,   1, 1, 0);
    add(0, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0,      8,   1, 0, 1);
    for (int i = 0; i < 10; i++) add(0, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0, 8, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,   0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,      1,   1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,      2,   0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,      3,   1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,      3,   1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,      3,   1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,      3,   0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'h010,  3,   0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,   0, 1, 0);
    add(0, 1, 1, 2, 0, 0, 0, 0, 1, 2, 'h040,  'h010, 0, 1, 0);
    add(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0,      'h040, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      'h041, 0, 1, 0);

    // reset values
    #1 reset = 1'b1;
    #1 chk_all("reset", 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick();
    chk_all("idle_after_reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].zr, vecs[i].sel, vecs[i].hl, vecs[i].so,
            vecs[i].ld, vecs[i].cl, vecs[i].we, vecs[i].wa, vecs[i].wd);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].sc, vecs[i].run, vecs[i].dn);
    end

    // full address sweep and wrap
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap start", int'(prog_ctr), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 1024; i++) begin
      tick();
      chk($sformatf("wrap pc%0d", i), int'(prog_ctr), i % 1024);
    end
    for (int i = 1; i <= 'hA7; i++) tick();
    chk("pre-reset pc", int'(prog_ctr), 'hA7);

    // asynchronous reset mid-RUN, checked before the next edge
    #2 reset = 1'b1;
    #1 chk_all("async reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle hold%0d", i), 0, 0, 0, 0);
    end

    // randomized phase against the model
    m_state = 0; m_pc = 0; m_sc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(39) == 0, $urandom_range(3) == 0, 1'($urandom),
            $urandom_range(7), $urandom_range(29) == 0, 1'($urandom),
            $urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
            $urandom_range(7), $urandom_range(1023));
      if (c == 0) start = 1'b1;
      model_step();
      tick();
      chk_all($sformatf("rand%0d", c), m_pc, m_sc, m_state == 1, m_state == 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and flag stage sitting directly downstream of the ALU: consumes the ALU's branch flag (`zero`) and shift-carry output (`sc_o`), and produces the next instruction address plus the registered carry fed back to the ALU's `sc_i`. Branch targets are absolute addresses held in a small writable lookup table, selected by an index field from the instruction. A three-state run controller handles start, halt, and done signalling for the test harness.

## Interface
- `PC_W`, default 10: program counter width; instruction memory depth is 2^PC_W.
- `LUT_W`, default 5: branch target table index width; the table has 2^LUT_W entries of `PC_W` bits.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: level sampled each edge; starts or restarts the program at address 0.
- `branch`  in  1: current instruction is a branch (decoder asserts this for ALU command 111).
- `zero`  in  1: ALU branch-condition result; 1 = taken.
- `target_sel`  in  LUT_W: branch target table index from the instruction.
- `halt`  in  1: current instruction is halt.
- `sc_o`  in  1: ALU shift-carry output.
- `sc_load`  in  1: capture `sc_o` into the carry register (shift instructions).
- `sc_clr`  in  1: clear the carry register.
- `lut_we`  in  1: branch target table write enable.
- `lut_waddr`  in  LUT_W: table write index.
- `lut_wdata`  in  PC_W: table write data (absolute target address).
- `prog_ctr`  out  PC_W: registered current instruction address.
- `sc_i`  out  1: registered shift carry to the ALU.
- `running`  out  1: 1 in RUN.
- `done`  out  1: 1 in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: `prog_ctr` holds. If `start` = 1, go to RUN with `prog_ctr` = 0 and `sc_i` = 0.
- RUN, priority per edge, highest first:
  1. `start` = 1: restart. `prog_ctr` = 0, `sc_i` = 0, stay in RUN.
  2. `halt` = 1: go to DONE. `prog_ctr` holds at the halt address; the carry register is not updated.
  3. `branch` = 1 and `zero` = 1: `prog_ctr` = table[`target_sel`].
  4. Otherwise: `prog_ctr` = `prog_ctr` + 1, modulo 2^PC_W. The maximum address wraps to 0.
- RUN with `branch` = 1 and `zero` = 0 is not taken and behaves as increment.
- `halt` and `branch` together: halt wins.
- DONE: `done` = 1 and `prog_ctr` holds. If `start` = 1, go to RUN with `prog_ctr` = 0 and `sc_i` = 0.
- In IDLE and DONE, `branch`, `zero`, `halt`, and `sc_load` are ignored.
- Carry register:
  - `sc_clr` = 1 clears it in any state; clear beats load.
  - `sc_load` = 1 captures `sc_o`, in RUN only.
  - Restart (`start` in any state) clears it.
- Branch target table:
  - Read is combinational from `target_sel`.
  - Write is synchronous on `lut_we`, in any state.
  - Simultaneous write and taken branch to the same index: the branch uses the old entry; the new value is visible the following cycle.

## Timing
- Reset values: `prog_ctr` = 0, `sc_i` = 0, `running` = 0, `done` = 0, state IDLE, all table entries 0.
- Reset takes effect immediately, without waiting for a clock edge, including mid-RUN.
- `start` seen high at edge N: `running` = 1 and `prog_ctr` = 0 after edge N. The instruction at address 0 is decoded during cycle N+1.
- Next-PC latency is one cycle. `branch`, `zero`, `halt`, and `target_sel` are combinational from the instruction at the current `prog_ctr` and take effect at the next edge.
- `sc_i` reflects `sc_o` one edge after `sc_load`, so a back-to-back shift sees the prior shift's carry-out.
- `done` and `running` are registered state decodes; they are never both 1.

## Test plan
- Reset, then `start` for one cycle with no branches and no halt: `prog_ctr` steps 0, 1, 2, ...; with PC_W = 10 it reaches 1023, then 0.
- Write table[3] = 0x155; at `prog_ctr` = 5, `branch` = 1, `zero` = 1, `target_sel` = 3: next `prog_ctr` = 0x155. Repeat with `zero` = 0: next `prog_ctr` = 6.
- At `prog_ctr` = 8, `halt` = 1 together with a taken branch: state DONE, `done` = 1, `prog_ctr` stays 8 for 10 cycles; then `start`: `prog_ctr` = 0, `running` = 1.
- In RUN: `sc_load` with `sc_o` = 1 gives `sc_i` = 1 next cycle. `sc_load` and `sc_clr` together give `sc_i` = 0. `sc_load` in DONE leaves `sc_i` unchanged.
- In one cycle, `lut_we` writes table[2] = 0x040 (old value 0x010) and a taken branch uses `target_sel` = 2: `prog_ctr` = 0x010. A repeat of the branch the next cycle gives 0x040.
- Assert `reset` asynchronously mid-RUN at `prog_ctr` = 0x0A7: all outputs go to 0 before the next edge, and the state stays IDLE until `start`.
